// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths and register-index types for the decode-stage register file
package core_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = reg_idx_t'(0);

endpackage

// File: rtl/regfile_bypass_sel.sv
// rtl/regfile_bypass_sel.sv - per-port read value select: write bypass plus hardwired R0
module regfile_bypass_sel
  import core_pkg::*;
#(
  parameter int DATA_W  = core_pkg::DATA_W_DEF,
  parameter int ADDR_W  = core_pkg::ADDR_W_DEF,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] sel_data
);

  always_comb begin
    sel_data = mem_data;
    if (wr_en && (wr_addr == rd_addr)) begin
      sel_data = wr_data;
    end
    // R0 wins over the bypass so an in-flight write to R0 is never visible.
    if (R0_ZERO && (rd_addr == ADDR_W'(REG_ZERO))) begin
      sel_data = '0;
    end
  end

endmodule

// File: rtl/regfile_dual_read.sv
// rtl/regfile_dual_read.sv - 8x16 register file, one write port, two registered bypassed read ports
module regfile_dual_read
  import core_pkg::*;
#(
  parameter int DATA_W  = core_pkg::DATA_W_DEF,
  parameter int ADDR_W  = core_pkg::ADDR_W_DEF,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rs1_sel;
  logic [DATA_W-1:0] rs2_sel;
  logic              wr_ok;

  assign wr_ok = wr_en && !(R0_ZERO && (wr_addr == ADDR_W'(REG_ZERO)));

  regfile_bypass_sel #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_sel_rs1 (
    .rd_addr  (rs1_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mem_data (mem[rs1_addr]),
    .sel_data (rs1_sel)
  );

  regfile_bypass_sel #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_sel_rs2 (
    .rd_addr  (rs2_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mem_data (mem[rs2_addr]),
    .sel_data (rs2_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rs1_data <= '0;
      rs2_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
      // Storage keeps updating under stall; only the read outputs freeze.
      if (!stall) begin
        if (rd_req) begin
          rs1_data <= rs1_sel;
          rs2_data <= rs2_sel;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_dual_read.sv
// tb/tb_regfile_dual_read.sv - scoreboard bench for regfile_dual_read
module tb_regfile_dual_read;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_req;
  logic [2:0]  rs1_addr;
  logic [2:0]  rs2_addr;
  logic        stall;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic        rd_valid;

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic        v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  regfile_dual_read dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .stall    (stall),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rs1_addr = '0; rs2_addr = '0; stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back({16'h0000, 16'h0000, 1'b0});
      step();
      e = sb.pop_front();
      checks++;
      if ({rs1_data, rs2_data, rd_valid} !== e) begin
        errors++;
        $display("FAIL reset_state: got %h %h %b expected %h %h %b", rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
      end
    end
    idle();
    rd_req = 1'b1; rs1_addr = 3'd3; rs2_addr = 3'd5;
    sb.push_back({16'h0000, 16'h0000, 1'b1});
    step();
    e = sb.pop_front();
    checks++;
    if ({rs1_data, rs2_data, rd_valid} !== e) begin
      errors++;
      $display("FAIL reset_readout: got %h %h %b expected %h %h %b", rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
    sb.push_back({16'h0000, 16'h0000, 1'b0});
    step();
    idle();
    rd_req = 1'b1; rs1_addr = 3'd2; rs2_addr = 3'd2;
    sb.push_back({16'hBEEF, 16'hBEEF, 1'b1});
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      checks++;
      if ({rs1_data, rs2_data, rd_valid} !== e) begin
        errors++;
        $display("FAIL write_read[%0d]: got %h %h %b expected %h %h %b", i, rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
      end
      if (i == 0) step();
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h00AA;
    sb.push_back({16'hBEEF, 16'hBEEF, 1'b0});
    step();
    e = sb.pop_front();
    checks++;
    if ({rs1_data, rs2_data, rd_valid} !== e) begin
      errors++;
      $display("FAIL bypass_setup_hold: got %h %h %b expected %h %h %b", rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
    end
    wr_addr = 3'd4; wr_data = 16'h1234;
    rd_req = 1'b1; rs1_addr = 3'd4; rs2_addr = 3'd1;
    sb.push_back({16'h1234, 16'h00AA, 1'b1});
    step();
    e = sb.pop_front();
    checks++;
    if ({rs1_data, rs2_data, rd_valid} !== e) begin
      errors++;
      $display("FAIL bypass: got %h %h %b expected %h %h %b", rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
    end
  endtask

  task automatic test_r0();
    idle();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    rd_req = 1'b1; rs1_addr = 3'd0; rs2_addr = 3'd4;
    sb.push_back({16'h0000, 16'h1234, 1'b1});
    step();
    idle();
    rd_req = 1'b1; rs1_addr = 3'd0; rs2_addr = 3'd0;
    sb.push_back({16'h0000, 16'h0000, 1'b1});
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      checks++;
      if ({rs1_data, rs2_data, rd_valid} !== e) begin
        errors++;
        $display("FAIL r0_zero[%0d]: got %h %h %b expected %h %h %b", i, rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
      end
      if (i == 0) step();
    end
  endtask

  task automatic test_stall();
    idle();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5A5A;
    step();
    idle();
    rd_req = 1'b1; rs1_addr = 3'd6; rs2_addr = 3'd6;
    sb.push_back({16'h5A5A, 16'h5A5A, 1'b1});
    step();
    stall = 1'b1; rs1_addr = 3'd7; rs2_addr = 3'd7;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      checks++;
      if ({rs1_data, rs2_data, rd_valid} !== e) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h %h %b expected %h %h %b", i, rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
      end
      if (i < 3) begin
        sb.push_back({16'h5A5A, 16'h5A5A, 1'b1});
        step();
        wr_en = 1'b0;
      end
    end
    idle();
    rd_req = 1'b1; rs1_addr = 3'd6; rs2_addr = 3'd6;
    sb.push_back({16'h0001, 16'h0001, 1'b1});
    step();
    e = sb.pop_front();
    checks++;
    if ({rs1_data, rs2_data, rd_valid} !== e) begin
      errors++;
      $display("FAIL stall_release: got %h %h %b expected %h %h %b", rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h0F0F;
    step();
    idle();
    rd_req = 1'b1; rs1_addr = 3'd3; rs2_addr = 3'd3;
    sb.push_back({16'h0F0F, 16'h0F0F, 1'b1});
    step();
    e = sb.pop_front();
    checks++;
    if ({rs1_data, rs2_data, rd_valid} !== e) begin
      errors++;
      $display("FAIL reset_mid_pre: got %h %h %b expected %h %h %b", rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
    end
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h7777;
    sb.push_back({16'h0000, 16'h0000, 1'b0});
    step();
    e = sb.pop_front();
    checks++;
    if ({rs1_data, rs2_data, rd_valid} !== e) begin
      errors++;
      $display("FAIL reset_mid_drop: got %h %h %b expected %h %h %b", rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
    end
    idle();
    rd_req = 1'b1; rs1_addr = 3'd3; rs2_addr = 3'd5;
    sb.push_back({16'h0000, 16'h0000, 1'b1});
    step();
    e = sb.pop_front();
    checks++;
    if ({rs1_data, rs2_data, rd_valid} !== e) begin
      errors++;
      $display("FAIL reset_mid_after: got %h %h %b expected %h %h %b", rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hC0DE;
    rd_req = 1'b1; rs1_addr = 3'd7; rs2_addr = 3'd3;
    sb.push_back({16'hC0DE, 16'h0000, 1'b1});
    step();
    wr_addr = 3'd3; wr_data = 16'h3333;
    rs1_addr = 3'd3; rs2_addr = 3'd7;
    sb.push_back({16'h3333, 16'hC0DE, 1'b1});
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      checks++;
      if ({rs1_data, rs2_data, rd_valid} !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h %h %b expected %h %h %b", i, rs1_data, rs2_data, rd_valid, e.d1, e.d2, e.v);
      end
      if (i == 0) step();
      if (i == 1) begin
        idle();
        sb.push_back({16'h3333, 16'hC0DE, 1'b0});
        step();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dual_read.md
Name: regfile_dual_read

Overview:
- 8 x 16-bit register file with one write port and two registered read ports (rs1/rs2) for the 16-bit RISC core's decode stage.
- Reads are pipelined: a read request is accepted in cycle N and its data is valid in cycle N+1.
- Write-to-read bypass makes a same-cycle write visible to the read.
- A stall input freezes the read outputs while execute is busy.

Parameters:
- DATA_W, 16, register and port data width.
- ADDR_W, 3, register address width; depth = 2**ADDR_W.
- R0_ZERO, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_req  in  1  read request; samples rs1_addr/rs2_addr
- rs1_addr  in  ADDR_W  read port 1 address
- rs2_addr  in  ADDR_W  read port 2 address
- stall  in  1  hold read outputs and ignore rd_req
- rs1_data  out  DATA_W  registered read data, port 1
- rs2_data  out  DATA_W  registered read data, port 2
- rd_valid  out  1  rs1_data/rs2_data valid for the last accepted request

Behaviour:
- Clock and reset: one clock (clk); synchronous, active-high reset (rst), sampled on the rising edge of clk only.
- Reset values:
  - All storage registers 0.
  - rs1_data = 0, rs2_data = 0, rd_valid = 0.
  - rst has priority over wr_en, rd_req and stall in the same cycle.
- Write:
  - On a clock edge with wr_en=1 and rst=0, mem[wr_addr] <= wr_data.
  - With R0_ZERO=1, writes to address 0 are dropped.
- Read acceptance:
  - A request is accepted when rd_req=1 and stall=0.
  - On an accepted edge: rsN_data <= bypassed value for rsN_addr, and rd_valid <= 1.
  - Latency is exactly 1 cycle.
- No request: rd_req=0 and stall=0 -> rd_valid <= 0; rsN_data keep their previous value.
- Stall: stall=1 -> rsN_data and rd_valid hold their current values, regardless of rd_req.
- Bypass rule (per port, evaluated combinationally before the output register):
  - If wr_en=1 and wr_addr==rsN_addr (and the address is not R0 when R0_ZERO=1), the value is wr_data.
  - Otherwise the value is mem[rsN_addr].
  - An accepted read therefore never returns stale data against a same-edge write.
- R0: with R0_ZERO=1, reading address 0 returns 0 even when a write to 0 is in flight.
- Same address on both ports: both outputs carry the identical value, bypass included.
- Writes during stall: storage updates normally. Held outputs are not refreshed; the next accepted read sees the new value.
- Reset mid-operation: a pending valid is dropped (rd_valid=0 the cycle after the rst edge). The first request after reset reads 0 unless a bypass applies.
- Address range: addresses cover the full 2**ADDR_W depth, so out-of-range access cannot occur.
- Storage: no asynchronous read path; storage is flops (no RAM inference required).

Decomposition:
- Shared package core_pkg:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO address constant (0).
  - Register-index typedef (reg_idx_t, ADDR_W bits).
- Sub-module regfile_bypass_sel, instantiated twice (one per read port):
  - Inputs: rd_addr, wr_en, wr_addr, wr_data, mem_data.
  - Output: selected value, with the R0 rule applied.
  - Combinational only.
- Top level holds storage, output registers, rd_valid and the stall/reset control.

Test Plan:
- Reset/readout:
  - Assert rst 2 cycles, release, rd_req with rs1=3, rs2=5.
  - Next cycle: rs1_data=0x0000, rs2_data=0x0000, rd_valid=1.
- Write then read:
  - Write 0xBEEF to R2; next cycle rd_req rs1=2, rs2=2.
  - One cycle later: both ports = 0xBEEF, rd_valid=1.
- Bypass:
  - Same cycle: wr_en=1, wr_addr=4, wr_data=0x1234; rd_req rs1=4, rs2=1 (R1 holds 0x00AA).
  - Next cycle: rs1_data=0x1234, rs2_data=0x00AA.
- R0 hardwired:
  - Write 0xFFFF to R0 with a same-cycle rd_req rs1=0.
  - rs1_data=0x0000, and it stays 0 on a later read.
- Stall hold:
  - Accepted read of R6=0x5A5A.
  - Then stall=1 for 3 cycles while rd_req=1 with rs1=7 and a write of 0x0001 to R6.
  - Outputs stay 0x5A5A with rd_valid=1 throughout.
  - After stall drops, a read of R6 returns 0x0001.
- Reset mid-operation:
  - Accepted read of R3=0x0F0F, then rst=1 together with rd_req=1.
  - Next cycle: rd_valid=0, rs1_data=0, rs2_data=0.
  - A read of R3 after reset returns 0x0000.
